// File: rtl/banner_scheduler.sv
// Digit-slot sequencer for the scrolling banner: rotation tick, 16-nibble message buffer,
// per-slot nibble/blank selection and scroll window over messages longer than four characters.
module banner_scheduler #(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned SCROLL_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] msg_len,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       tick_display,
  output logic [3:0] value,
  output logic       off_display,
  output logic [1:0] digit_idx,
  output logic [3:0] scroll_pos
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [PW-1:0] PreMax   = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FrameMax = FW'(SCROLL_FRAMES - 1);

  typedef enum logic [1:0] {StBlank, StStatic, StScroll} state_e;

  state_e        state_q, state_d, state_new;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0]    scroll_q, scroll_d;
  logic [4:0]    len_q, len_d, len_clamp;
  logic          boundary;
  logic [1:0]    slot_i;
  logic [4:0]    sum;
  logic [3:0]    rd_addr;
  logic [3:0]    mem_q [16];

  assign tick_display = (pre_q == PreMax);
  assign boundary     = tick_display && (digit_q == 2'd3);
  assign digit_idx    = digit_q;
  assign scroll_pos   = scroll_q;
  assign len_clamp    = (msg_len > 5'd16) ? 5'd16 : msg_len;

  always_comb begin
    if (!enable || len_clamp == 5'd0) begin
      state_new = StBlank;
    end else if (len_clamp <= 5'd4) begin
      state_new = StStatic;
    end else begin
      state_new = StScroll;
    end
  end

  always_comb begin
    pre_d    = tick_display ? '0 : pre_q + PW'(1);
    digit_d  = tick_display ? digit_q + 2'd1 : digit_q;
    state_d  = state_q;
    len_d    = len_q;
    frame_d  = frame_q;
    scroll_d = scroll_q;
    if (boundary) begin
      len_d   = len_clamp;
      state_d = state_new;
      // Window restarts on any length change and whenever we are not continuing a scroll.
      if (len_clamp != len_q || state_new != StScroll || state_q != StScroll) begin
        frame_d  = '0;
        scroll_d = '0;
      end else if (frame_q == FrameMax) begin
        frame_d  = '0;
        scroll_d = (5'(scroll_q) + 5'd1 == len_q) ? 4'd0 : scroll_q + 4'd1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q    <= '0;
      digit_q  <= '0;
      frame_q  <= '0;
      scroll_q <= '0;
      len_q    <= '0;
      state_q  <= StBlank;
    end else begin
      pre_q    <= pre_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      scroll_q <= scroll_d;
      len_q    <= len_d;
      state_q  <= state_d;
    end
  end

  // Buffer is deliberately not reset so the message survives a scheduler reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Slot k shows message index scroll_pos+3-k; in STATIC scroll_q is 0 and the index < len_q.
  assign slot_i  = ~digit_q;
  assign sum     = 5'(scroll_q) + 5'(slot_i);
  assign rd_addr = (sum >= len_q) ? 4'(sum - len_q) : sum[3:0];

  always_comb begin
    value       = 4'd0;
    off_display = 1'b1;
    unique case (state_q)
      StStatic: begin
        if (5'(slot_i) < len_q) begin
          value       = mem_q[rd_addr];
          off_display = 1'b0;
        end
      end
      StScroll: begin
        value       = mem_q[rd_addr];
        off_display = 1'b0;
      end
      default: begin
        value       = 4'd0;
        off_display = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_banner_scheduler.sv
// Directed bench for banner_scheduler with TICK_DIV=4, SCROLL_FRAMES=2 (16 clocks per frame).
module tb_banner_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [4:0] msg_len;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       tick_display;
  logic [3:0] value;
  logic       off_display;
  logic [1:0] digit_idx;
  logic [3:0] scroll_pos;

  int tests;
  int failed;
  logic [15:0] scroll_tbl [6];

  banner_scheduler #(
    .TICK_DIV     (4),
    .SCROLL_FRAMES(2)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .msg_len     (msg_len),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .tick_display(tick_display),
    .value       (value),
    .off_display (off_display),
    .digit_idx   (digit_idx),
    .scroll_pos  (scroll_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic write(input logic [3:0] addr, input logic [3:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns on the negedge of a frame-boundary cycle (tick with digit_idx==3).
  task automatic wait_boundary();
    int n;
    n = 0;
    @(negedge clk);
    while (!(tick_display && digit_idx == 2'd3) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++;
      failed++;
      $display("FAIL boundary_timeout: no frame boundary within 64 cycles (t=%0t)", $time);
    end
  endtask

  // Starts and ends on a boundary negedge; vals nibble k / offs bit k are for slot k.
  task automatic check_frame(input string tag, input logic [3:0] sp, input logic [15:0] vals,
                             input logic [3:0] offs);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_digit"}, 32'(digit_idx), 32'(k));
      check({tag, "_scroll"}, 32'(scroll_pos), 32'(sp));
      check({tag, "_value"}, 32'(value), 32'(vals[k*4 +: 4]));
      check({tag, "_off"}, 32'(off_display), 32'(offs[k]));
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tests   = 0;
    failed  = 0;
    rst     = 1'b0;
    enable  = 1'b0;
    msg_len = 5'd0;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 4'd0;
    scroll_tbl[0] = 16'h0123;
    scroll_tbl[1] = 16'h1234;
    scroll_tbl[2] = 16'h2345;
    scroll_tbl[3] = 16'h3450;
    scroll_tbl[4] = 16'h4501;
    scroll_tbl[5] = 16'h5012;

    // Reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tick", 32'(tick_display), 0);
    check("rst_digit", 32'(digit_idx), 0);
    check("rst_scroll", 32'(scroll_pos), 0);
    check("rst_off", 32'(off_display), 1);
    check("rst_value", 32'(value), 0);
    rst = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) @(negedge clk);
      check("tick_seq", 32'(tick_display), 32'(n % 4 == 3));
      check("digit_seq", 32'(digit_idx), 32'((n / 4) % 4));
      check("blank_off", 32'(off_display), 1);
    end

    // Static 4-character message
    write(4'd0, 4'd1);
    write(4'd1, 4'd2);
    write(4'd2, 4'd3);
    write(4'd3, 4'd4);
    msg_len = 5'd4;
    enable  = 1'b1;
    wait_boundary();
    check_frame("static_a", 4'd0, 16'h1234, 4'b0000);
    check_frame("static_b", 4'd0, 16'h1234, 4'b0000);

    // Write to the address being displayed: old data this cycle, new data next
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 4'd7;
    #1;
    check("wr_old", 32'(value), 4);
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_new", 32'(value), 7);

    // Short message
    write(4'd0, 4'hA);
    write(4'd1, 4'hB);
    msg_len = 5'd2;
    wait_boundary();
    check_frame("short", 4'd0, 16'hAB00, 4'b0011);

    // Scroll through a 6-character message, including the wrap back to 0
    for (int i = 0; i < 6; i++) write(4'(i), 4'(i));
    msg_len = 5'd6;
    wait_boundary();
    for (int s = 0; s < 6; s++) begin
      for (int f = 0; f < 2; f++) check_frame("scroll", 4'(s), scroll_tbl[s], 4'b0000);
    end
    check_frame("scroll_wrap", 4'd0, scroll_tbl[0], 4'b0000);
    repeat (10) wait_boundary();

    // Length change mid-frame at scroll_pos 5 takes effect only at the boundary
    fork
      check_frame("len_mid", 4'd5, scroll_tbl[5], 4'b0000);
      begin
        repeat (6) @(negedge clk);
        msg_len = 5'd5;
      end
    join
    check_frame("len5", 4'd0, 16'h0123, 4'b0000);

    // msg_len above 16 clamps to 16, which still scrolls
    msg_len = 5'd20;
    check_frame("len16_a", 4'd0, 16'h0123, 4'b0000);
    check_frame("len16_b", 4'd0, 16'h0123, 4'b0000);

    // Disable mid-frame: frame completes, then blank
    fork
      check_frame("dis_mid", 4'd1, 16'h1234, 4'b0000);
      begin
        repeat (6) @(negedge clk);
        enable = 1'b0;
      end
    join
    check_frame("blank", 4'd0, 16'h0000, 4'b1111);

    // Reset during SCROLL
    enable = 1'b1;
    check_frame("rescroll", 4'd0, 16'h0123, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_tick", 32'(tick_display), 0);
    check("rst2_digit", 32'(digit_idx), 0);
    check("rst2_scroll", 32'(scroll_pos), 0);
    check("rst2_off", 32'(off_display), 1);
    check("rst2_value", 32'(value), 0);
    rst     = 1'b1;
    msg_len = 5'd4;
    wait_boundary();
    check_frame("retain", 4'd0, 16'h0123, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/banner_scheduler.md
Name: banner_scheduler

Overview:
Sequencer that drives the 7-segment driver for the scrolling banner. It generates the digit-rotation tick and holds a 16-nibble message buffer. For each digit slot it presents the matching nibble and per-digit blank, and advances a scroll window across messages longer than four characters. It sits between the host/config logic and the 7-segment driver, and its digit index stays in lock-step with the driver's one-hot anode rotation.

Parameters:
TICK_DIV, 50000, clocks per digit slot; must be at least 2; prescaler width is $clog2(TICK_DIV).
SCROLL_FRAMES, 64, full 4-digit frames per scroll step; must be at least 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset (0 = reset)
enable  input  1  display enable; sampled only at frame boundary
msg_len  input  5  message length 0..16; values above 16 are clamped to 16; sampled only at frame boundary
wr_en  input  1  message buffer write strobe
wr_addr  input  4  message buffer write address
wr_data  input  4  message nibble
tick_display  output  1  one-cycle pulse that advances the driver's anode
value  output  4  nibble for the current digit slot, to the driver
off_display  output  1  blank the current digit slot, to the driver
digit_idx  output  2  current slot; slot k = anode bit k; slot 3 is leftmost
scroll_pos  output  4  message index currently shown on slot 3

Behaviour:
- Reset (rst=0 at a clk edge), values at the next edge:
  - prescaler=0, tick_display=0, digit_idx=0, frame_cnt=0, scroll_pos=0, len_q=0, state=BLANK.
  - Outputs: off_display=1, value=0.
- Reset and the buffer:
  - The message buffer is not reset; contents are undefined until written.
  - The driver's reset must be asserted on the same cycles as rst, so that driver anode bit 0 aligns with digit_idx=0.
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps, and runs independent of state.
  - tick_display=1 for exactly the one cycle where prescaler==TICK_DIV-1, so the period is TICK_DIV clocks.
- digit_idx: increments mod 4 on the clk edge that ends a tick cycle, which is the same edge on which the driver rotates its anodes.
- Frame boundary:
  - Definition: the cycle where tick_display=1 and digit_idx==3.
  - At each boundary: len_q <= min(msg_len,16); enable is sampled; state is re-evaluated.
  - If the new len_q differs from the old len_q, scroll_pos <= 0 and frame_cnt <= 0.
  - Otherwise frame_cnt increments.
- States, evaluated only at a frame boundary:
  - BLANK: enable=0 or len_q==0.
  - STATIC: len_q 1..4.
  - SCROLL: len_q 5..16.
- BLANK output: off_display=1, value=0.
- STATIC output:
  - Slot k shows index i=3-k.
  - If i<len_q: value=buf[i], off_display=0.
  - Else: off_display=1, value=0.
  - scroll_pos is held at 0.
- SCROLL output:
  - Slot k shows buf[(scroll_pos+3-k) mod len_q]; off_display=0.
  - When frame_cnt reaches SCROLL_FRAMES-1 at a boundary: frame_cnt <= 0 and scroll_pos <= (scroll_pos+1) mod len_q, wrapping len_q-1 to 0.
  - Leaving SCROLL clears scroll_pos and frame_cnt.
- Output timing: value and off_display are combinational from the registered digit_idx, scroll_pos, len_q, state and buffer, so they are valid for the whole slot.
- Writes:
  - Synchronous; visible on value from the cycle after the write.
  - Writes are allowed in any state and at any time.
  - A simultaneous write and read of the same address shows the old data during the write cycle.
- Mid-frame changes to enable or msg_len have no effect until the next frame boundary, so there is no frame tearing.

Test Plan (TICK_DIV=4, SCROLL_FRAMES=2; one frame = 16 clocks):
1. Reset: hold rst=0 for 5 cycles, then release. Required: tick_display, digit_idx, scroll_pos=0; off_display=1; value=0. The first tick_display pulse is the 4th cycle after release, then one every 4 cycles; digit_idx steps 0,1,2,3,0.
2. Static: write buf[0..3]=1,2,3,4, msg_len=4, enable=1. After the next frame boundary, slots 3/2/1/0 show 1/2/3/4 with off_display=0, repeating every frame.
3. Short message: buf[0..1]=A,B, msg_len=2. Required: slot 3=A, slot 2=B, slots 1 and 0 off_display=1, value=0.
4. Scroll: buf[0..5]=0..5, msg_len=6. Required: scroll_pos steps every 32 clocks in the sequence 0,1,2,3,4,5,0. At scroll_pos=4, slots 3..0 show 4,5,0,1.
5. Length change: at scroll_pos=5 set msg_len=5 mid-frame. Required: display is unchanged until the boundary, then scroll_pos=0, frame_cnt=0. Separately, msg_len=20 gives len_q=16.
6. Disable and reset mid-operation:
   - Drop enable mid-frame: the frame completes, then BLANK with off_display=1 on all slots.
   - Assert rst during SCROLL: all registers take their reset values at the next edge.
   - Buffer contents are retained across reset: after re-enable, the first STATIC frame shows the pre-reset data.
